// File: rtl/ddr4_rx_lane_eye_trainer_if.sv
// Signal bundle between the RX eye trainer, the training sequencer and the RX IOD delay line.
//   start / exp_pattern            : sequencer request and expected training word
//   rx_data / delay_line_out_of_range : lane word and limit flag from the IOD
//   delay_line_load/move/direction : delay-line controls driven by the trainer
//   busy / done / fail / tap_value / eye_width : training status driven by the trainer
// The slave modport is the trainer's view; master is the sequencer/IOD side.
interface ddr4_rx_lane_eye_trainer_if;
  logic       start;
  logic [3:0] rx_data;
  logic [3:0] exp_pattern;
  logic       delay_line_out_of_range;
  logic       delay_line_load;
  logic       delay_line_move;
  logic       delay_line_direction;
  logic       busy;
  logic       done;
  logic       fail;
  logic [7:0] tap_value;
  logic [7:0] eye_width;

  modport master (
    output start, rx_data, exp_pattern, delay_line_out_of_range,
    input  delay_line_load, delay_line_move, delay_line_direction,
    input  busy, done, fail, tap_value, eye_width
  );

  modport slave (
    input  start, rx_data, exp_pattern, delay_line_out_of_range,
    output delay_line_load, delay_line_move, delay_line_direction,
    output busy, done, fail, tap_value, eye_width
  );
endinterface

// File: rtl/ddr4_rx_lane_eye_trainer.sv
// Read-side delay-line training for one 4:1 deserialized DDR4 receive lane. Sweeps the input
// delay line upward from tap 0, marks taps where every sampled word matches the training
// pattern, then steps back down to the centre of the first passing eye.
// Ports:
//   fab_clk : fabric clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : trainer side of ddr4_rx_lane_eye_trainer_if (request, lane data, delay-line
//             controls, status)
// All outputs are registered.
module ddr4_rx_lane_eye_trainer #(
  parameter int unsigned TapMax       = 127,
  parameter int unsigned SettleCycles = 8,
  parameter int unsigned SampleWords  = 16,
  parameter int unsigned MinEye       = 2
) (
  input logic                             fab_clk,
  input logic                             reset_n,
  ddr4_rx_lane_eye_trainer_if.slave       bus
);

  typedef enum logic [3:0] {
    StIdle, StLoad, StSettle, StSample, StEval, StStep, StCenter, StDone, StFail
  } state_e;

  state_e      state_q;
  logic [7:0]  tap_cur_q, left_q, right_q, centre_q, moves_left_q, width_q;
  logic        found_q, pass_q, from_step_q;
  logic [15:0] cnt_q;
  logic        load_q, move_q, dir_q, busy_q, done_q, fail_q;
  logic [7:0]  tap_value_q, eye_width_q;

  // Eye bookkeeping as it will stand after this cycle, so the end-of-sweep decision in EVAL
  // sees the tap just evaluated.
  logic       eval_pass;
  logic       found_c;
  logic [7:0] left_c, right_c, centre_c, tap_end_c, width_sat;
  logic [8:0] width_c, sum_c;
  logic       eye_ok, end_sweep;

  always_comb begin
    eval_pass = (state_q == StEval) && pass_q;
    found_c   = found_q | eval_pass;
    left_c    = (eval_pass && !found_q) ? tap_cur_q : left_q;
    right_c   = eval_pass ? tap_cur_q : right_q;
    // 9-bit width: left 0 / right 255 gives 256, saturated for the 8-bit status output.
    width_c   = {1'b0, right_c} - {1'b0, left_c} + 9'd1;
    sum_c     = {1'b0, left_c} + {1'b0, right_c};
    centre_c  = 8'(sum_c >> 1);
    width_sat = width_c[8] ? 8'hFF : width_c[7:0];
    eye_ok    = found_c && (width_c >= 9'(MinEye));
    // A rejected move leaves the line one tap below what we counted.
    tap_end_c = (state_q == StSettle) ? tap_cur_q - 8'd1 : tap_cur_q;
    end_sweep = ((state_q == StSettle) && from_step_q && bus.delay_line_out_of_range) ||
                ((state_q == StEval) &&
                 ((!pass_q && found_q) || (tap_cur_q == 8'(TapMax))));
  end

  always_ff @(posedge fab_clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      tap_cur_q    <= '0;
      left_q       <= '0;
      right_q      <= '0;
      centre_q     <= '0;
      moves_left_q <= '0;
      width_q      <= '0;
      found_q      <= 1'b0;
      pass_q       <= 1'b0;
      from_step_q  <= 1'b0;
      cnt_q        <= '0;
      load_q       <= 1'b0;
      move_q       <= 1'b0;
      dir_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      tap_value_q  <= '0;
      eye_width_q  <= '0;
    end else begin
      load_q <= 1'b0;
      move_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            tap_value_q <= '0;
            eye_width_q <= '0;
            busy_q      <= 1'b1;
            load_q      <= 1'b1;
            state_q     <= StLoad;
          end
        end
        StLoad: begin
          tap_cur_q   <= '0;
          found_q     <= 1'b0;
          left_q      <= '0;
          right_q     <= '0;
          from_step_q <= 1'b0;
          cnt_q       <= '0;
          state_q     <= StSettle;
        end
        StSettle: begin
          if (end_sweep) begin
            tap_cur_q <= tap_end_c;
            width_q   <= found_c ? width_sat : 8'd0;
            centre_q  <= centre_c;
            if (eye_ok) begin
              moves_left_q <= tap_end_c - centre_c;
              state_q      <= StCenter;
            end else begin
              load_q  <= 1'b1;
              state_q <= StFail;
            end
          end else if (cnt_q == 16'(SettleCycles - 1)) begin
            cnt_q   <= '0;
            pass_q  <= 1'b1;
            state_q <= StSample;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StSample: begin
          pass_q <= pass_q & (bus.rx_data == bus.exp_pattern);
          if (cnt_q == 16'(SampleWords - 1)) begin
            cnt_q   <= '0;
            state_q <= StEval;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StEval: begin
          found_q <= found_c;
          left_q  <= left_c;
          right_q <= right_c;
          if (end_sweep) begin
            tap_cur_q <= tap_end_c;
            width_q   <= found_c ? width_sat : 8'd0;
            centre_q  <= centre_c;
            if (eye_ok) begin
              moves_left_q <= tap_end_c - centre_c;
              state_q      <= StCenter;
            end else begin
              load_q  <= 1'b1;
              state_q <= StFail;
            end
          end else begin
            move_q  <= 1'b1;
            dir_q   <= 1'b1;
            state_q <= StStep;
          end
        end
        StStep: begin
          tap_cur_q   <= tap_cur_q + 8'd1;
          from_step_q <= 1'b1;
          cnt_q       <= '0;
          state_q     <= StSettle;
        end
        StCenter: begin
          // A pulse cycle is always followed by an idle cycle.
          if (!move_q) begin
            if (moves_left_q != 8'd0) begin
              move_q       <= 1'b1;
              dir_q        <= 1'b0;
              moves_left_q <= moves_left_q - 8'd1;
              tap_cur_q    <= tap_cur_q - 8'd1;
            end else begin
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          tap_value_q <= centre_q;
          eye_width_q <= width_q;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= StIdle;
        end
        StFail: begin
          tap_value_q <= '0;
          eye_width_q <= width_q;
          fail_q      <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.delay_line_load      = load_q;
  assign bus.delay_line_move      = move_q;
  assign bus.delay_line_direction = dir_q;
  assign bus.busy                 = busy_q;
  assign bus.done                 = done_q;
  assign bus.fail                 = fail_q;
  assign bus.tap_value            = tap_value_q;
  assign bus.eye_width            = eye_width_q;

endmodule

// File: tb/tb_ddr4_rx_lane_eye_trainer.sv
// Directed bench for ddr4_rx_lane_eye_trainer with a behavioural delay-line model.
module tb_ddr4_rx_lane_eye_trainer;

  logic fab_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 fab_clk = ~fab_clk;

  ddr4_rx_lane_eye_trainer_if bus ();

  ddr4_rx_lane_eye_trainer #(
    .TapMax      (15),
    .SettleCycles(2),
    .SampleWords (4),
    .MinEye      (2)
  ) dut (
    .fab_clk(fab_clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // Delay-line model: passing window [eye_lo, eye_hi]; an up move from oor_lim is rejected.
  int         eye_lo  = 1;
  int         eye_hi  = 0;
  int         oor_lim = 255;
  logic [7:0] m_tap   = 8'd0;
  logic       m_oor   = 1'b0;

  always @(posedge fab_clk) begin
    if (bus.delay_line_load) begin
      m_tap <= 8'd0;
      m_oor <= 1'b0;
    end else if (bus.delay_line_move) begin
      if (bus.delay_line_direction) begin
        if (int'(m_tap) >= oor_lim) m_oor <= 1'b1;
        else m_tap <= m_tap + 8'd1;
      end else begin
        m_oor <= 1'b0;
        if (m_tap != 8'd0) m_tap <= m_tap - 8'd1;
      end
    end
  end

  assign bus.rx_data = (int'(m_tap) >= eye_lo && int'(m_tap) <= eye_hi) ? 4'hA : 4'h5;
  assign bus.delay_line_out_of_range = m_oor;

  // Pulse monitor.
  int   n_load = 0, n_up = 0, n_down = 0, proto_err = 0;
  logic prev_pulse = 1'b0;

  always @(negedge fab_clk) begin
    if (bus.delay_line_load) n_load <= n_load + 1;
    if (bus.delay_line_move && bus.delay_line_direction) n_up <= n_up + 1;
    if (bus.delay_line_move && !bus.delay_line_direction) n_down <= n_down + 1;
    if ((bus.delay_line_load && bus.delay_line_move) ||
        (prev_pulse && (bus.delay_line_load || bus.delay_line_move)))
      proto_err <= proto_err + 1;
    prev_pulse <= bus.delay_line_load | bus.delay_line_move;
  end

  typedef struct {
    logic       done;
    logic [7:0] tap;
    logic [7:0] width;
    int         up;
    int         down;
    int         loads;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return {8'd0, bus.delay_line_load, bus.delay_line_move, bus.delay_line_direction,
            bus.busy, bus.done, bus.fail, 2'b00, bus.tap_value, bus.eye_width};
  endfunction

  task automatic kick();
    @(negedge fab_clk);
    bus.start = 1'b1;
    @(negedge fab_clk);
    bus.start = 1'b0;
    check("load_after_start", 32'(bus.delay_line_load), 1);
    check("busy_after_start", 32'(bus.busy), 1);
  endtask

  task automatic wait_end();
    int cyc = 0;
    while (!(bus.done || bus.fail) && cyc < 3000) begin
      @(negedge fab_clk);
      cyc++;
    end
    check("finished", 32'(bus.done | bus.fail), 1);
  endtask

  task automatic train(input int lo, input int hi, input int lim, input exp_t e);
    int   b_load, b_up, b_down;
    exp_t got;
    eye_lo  = lo;
    eye_hi  = hi;
    oor_lim = lim;
    sb.push_back(e);
    b_load = n_load;
    b_up   = n_up;
    b_down = n_down;
    kick();
    wait_end();
    got = sb.pop_front();
    check("done", 32'(bus.done), 32'(got.done));
    check("fail", 32'(bus.fail), 32'(!got.done));
    check("tap_value", 32'(bus.tap_value), 32'(got.tap));
    check("eye_width", 32'(bus.eye_width), 32'(got.width));
    check("busy_end", 32'(bus.busy), 0);
    check("up_moves", 32'(n_up - b_up), 32'(got.up));
    check("down_moves", 32'(n_down - b_down), 32'(got.down));
    check("loads", 32'(n_load - b_load), 32'(got.loads));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_load, b_up, b_down, cyc;
    bus.start       = 1'b0;
    bus.exp_pattern = 4'hA;

    // Reset state and START while in reset.
    repeat (3) @(negedge fab_clk);
    check("reset_outputs", outs_vec(), 0);
    b_load      = n_load;
    bus.start   = 1'b1;
    @(negedge fab_clk);
    bus.start   = 1'b0;
    reset_n     = 1'b1;
    repeat (3) @(negedge fab_clk);
    check("start_in_reset_busy", 32'(bus.busy), 0);
    check("start_in_reset_load", 32'(n_load - b_load), 0);

    // Centre eye; right edge from a failing tap.
    train(5, 9, 255, '{1'b1, 8'd7, 8'd5, 10, 3, 1});
    repeat (3) @(negedge fab_clk);
    check("done_held", 32'(bus.done), 1);

    // Eye runs into TAP_MAX.
    train(12, 15, 255, '{1'b1, 8'd13, 8'd4, 15, 2, 1});
    // Delay line rejects the move to tap 8.
    train(5, 12, 7, '{1'b1, 8'd6, 8'd3, 8, 1, 1});
    // No passing tap.
    train(1, 0, 255, '{1'b0, 8'd0, 8'd0, 15, 0, 2});
    // Eye narrower than MIN_EYE.
    train(4, 4, 255, '{1'b0, 8'd0, 8'd1, 5, 0, 2});

    // Extra START mid-sweep, then reset during CENTER.
    eye_lo  = 5;
    eye_hi  = 9;
    oor_lim = 255;
    b_load  = n_load;
    kick();
    repeat (20) @(negedge fab_clk);
    check("busy_mid_sweep", 32'(bus.busy), 1);
    bus.start = 1'b1;
    @(negedge fab_clk);
    bus.start = 1'b0;
    cyc = 0;
    while (!(bus.delay_line_move && !bus.delay_line_direction) && cyc < 3000) begin
      @(negedge fab_clk);
      cyc++;
    end
    check("center_reached", 32'(bus.delay_line_move & ~bus.delay_line_direction), 1);
    check("extra_start_loads", 32'(n_load - b_load), 1);
    reset_n = 1'b0;
    @(negedge fab_clk);
    check("abort_outputs", outs_vec(), 0);
    b_up   = n_up;
    b_down = n_down;
    b_load = n_load;
    repeat (3) @(negedge fab_clk);
    reset_n = 1'b1;
    repeat (10) @(negedge fab_clk);
    check("no_moves_after_abort", 32'((n_up - b_up) + (n_down - b_down)), 0);
    check("no_load_after_abort", 32'(n_load - b_load), 0);
    check("idle_after_abort", 32'(bus.busy | bus.done | bus.fail), 0);

    // Retrain to the same result.
    train(5, 9, 255, '{1'b1, 8'd7, 8'd5, 10, 3, 1});

    check("pulse_spacing", 32'(proto_err), 0);
    check("scoreboard_empty", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ddr4_rx_lane_eye_trainer.md
# ddr4_rx_lane_eye_trainer

Read-side delay-line training controller for one DDR4 PHY receive lane. The lane's IOD deserializes 4:1, so this block sees one 4-bit word per FAB_CLK cycle. It sweeps the lane's dynamic input delay line from tap 0 upward, compares the received words against a known training pattern, and finds the passing eye. It then steps the delay line back to the eye centre. It sits in the fabric between the DDR training sequencer and the RX IOD delay-line controls, the receive counterpart of the TX-only command/address IOD lanes.

## Interface
- TAP_MAX, 127: highest legal delay tap, range 1..255.
- SETTLE_CYCLES, 8: wait cycles after any delay-line load or move, before sampling starts; minimum 1.
- SAMPLE_WORDS, 16: consecutive words compared per tap; minimum 1.
- MIN_EYE, 2: minimum passing-window width in taps; a narrower eye is a failure.
- FAB_CLK  in  1  fabric clock; all logic is on its rising edge.
- RESET_N  in  1  synchronous, active-low reset.
- START  in  1  one-cycle request to train; sampled only in IDLE.
- RX_DATA  in  4  deserialized lane word, valid every cycle.
- EXP_PATTERN  in  4  expected word; must be static while BUSY.
- DELAY_LINE_OUT_OF_RANGE  in  1  delay line reports that the last move was rejected at its limit.
- DELAY_LINE_LOAD  out  1  one-cycle pulse; resets the delay line to tap 0.
- DELAY_LINE_MOVE  out  1  one-cycle pulse; moves the delay line one tap.
- DELAY_LINE_DIRECTION  out  1  1 = increment, 0 = decrement; valid in the same cycle as MOVE.
- BUSY  out  1  high from START acceptance until DONE or FAIL.
- DONE  out  1  level; training succeeded.
- FAIL  out  1  level; no eye was found, or the eye was narrower than MIN_EYE.
- TAP_VALUE  out  8  final tap: the centre tap on DONE, 0 on FAIL.
- EYE_WIDTH  out  8  right − left + 1 on DONE; 0 if no passing tap was found.

## Operation
- States: IDLE, LOAD, SETTLE, SAMPLE, EVAL, STEP, CENTER, DONE, FAIL.
- IDLE: on START, clear DONE, FAIL, TAP_VALUE and EYE_WIDTH, set BUSY, go to LOAD.
- LOAD: pulse DELAY_LINE_LOAD; set tap_cur = 0, found = 0; go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles.
  - If OUT_OF_RANGE is seen high in any SETTLE cycle following a STEP, the move did not apply. Set tap_cur −= 1 and end the sweep.
- SAMPLE: exactly SAMPLE_WORDS cycles. The tap passes only if every RX_DATA equals EXP_PATTERN. The window length is fixed; there is no early exit.
- EVAL, if the tap passed:
  - If found = 0, set left = tap_cur and found = 1.
  - Set right = tap_cur.
- EVAL, if the tap failed and found = 1: end the sweep (the right edge is found).
- EVAL, otherwise: if tap_cur = TAP_MAX, end the sweep; else go to STEP.
- STEP: pulse MOVE with DIRECTION = 1; tap_cur += 1; go to SETTLE.
- End of sweep:
  - If found = 0 or (right − left + 1) < MIN_EYE, go to FAIL.
  - Otherwise centre = (left + right) >> 1 (floor) and go to CENTER.
- CENTER: issue (tap_cur − centre) MOVE pulses with DIRECTION = 0, one pulse then one idle cycle each. Then go to DONE.
- DONE: TAP_VALUE = centre, EYE_WIDTH = width, DONE = 1, BUSY = 0; return to IDLE with DONE held.
- FAIL: pulse LOAD once (the delay line returns to tap 0); TAP_VALUE = 0; EYE_WIDTH = width, or 0 if found = 0; FAIL = 1, BUSY = 0; return to IDLE.
- Arithmetic: all tap math is 8-bit unsigned. Width and centre are computed without overflow for TAP_MAX ≤ 255.

## Timing
- Reset: all outputs are 0 on the first FAB_CLK edge with RESET_N low. State goes to IDLE; counters and registers go to 0.
- Reset mid-operation aborts immediately, with no cleanup pulses. The sequencer must retrain.
- The LOAD pulse occurs in the cycle after START is accepted.
- START while BUSY is ignored. START in the same cycle as RESET_N low is ignored.
- MOVE and LOAD are never high in the same cycle, and never in consecutive cycles.
- Per-tap cost is SETTLE_CYCLES + SAMPLE_WORDS + 2 cycles (EVAL and STEP).
- DONE and FAIL hold until the next accepted START or reset.

## Test plan
- Bench setup: TAP_MAX = 15, SETTLE_CYCLES = 2, SAMPLE_WORDS = 4, MIN_EYE = 2. A bench delay-line model returns EXP_PATTERN = 4'hA inside the eye and 4'h5 outside it.
- Eye [5,9] -> 1 LOAD; 10 up MOVEs (tap reaches 10); 3 down MOVEs; DONE; TAP_VALUE = 7; EYE_WIDTH = 5.
- Eye [12,15], sweep reaches TAP_MAX still passing -> right = 15; 2 down MOVEs; TAP_VALUE = 13; EYE_WIDTH = 4.
- Eye [5,12], model asserts OUT_OF_RANGE after the move to tap 8 -> tap_cur = 7; right = 7; 1 down MOVE; TAP_VALUE = 6; EYE_WIDTH = 3.
- No passing tap, then separately eye [4,4] -> FAIL both times; EYE_WIDTH 0 and 1 respectively; a final LOAD pulse; TAP_VALUE = 0.
- START pulsed during the sweep, then RESET_N low during CENTER -> the extra START has no effect. After reset, all outputs are 0 next cycle and no further MOVE occurs. A new START retrains to the same result.
